// File: rtl/s2_window_buffer.sv
// S2 -> C3 window generator: K-1 line buffers per channel feed a KxK shift window; every completed
// window is latched onto a held valid/ready output. Optional coordinate outputs under S2WB_COORD_EN.
module s2_window_buffer #(
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int K     = 5,
  parameter int CH    = 6,
  parameter int DW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_clr,
  input  logic                  in_valid,
  input  logic [CH*DW-1:0]      in_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [CH*K*K*DW-1:0]  win_data,
  output logic                  win_last,
  output logic                  frame_done,
  output logic                  overflow
`ifdef S2WB_COORD_EN
  ,
  output logic [3:0]            win_row,
  output logic [3:0]            win_col
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = CH * K * K * DW;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          win_valid_q;
  logic [WW-1:0] win_data_q;
  logic          win_last_q;
  logic          frame_done_q;
  logic          overflow_q;
  logic [WW-1:0] win_d;
  logic          accept;
  logic          last_pix;
  logic          complete;

  // Clears and reset both win over a pixel arriving in the same cycle.
  assign accept   = rst_n && !frame_clr && in_valid;
  assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  assign complete = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  genvar gi, gr, gc;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [DW-1:0] lb_q [K-1][IMG_W];
      logic [DW-1:0] sh_q [K][K-1];
      logic [DW-1:0] col_pix [K];

      for (gr = 0; gr < K; gr++) begin : g_row
        if (gr == K - 1) begin : g_new
          assign col_pix[gr] = in_data[gi*DW +: DW];
        end else begin : g_lb
          assign col_pix[gr] = lb_q[gr][col_q];
        end
        // sh_q holds columns 1..K-1 of the current window; the incoming column becomes the rightmost.
        for (gc = 0; gc < K; gc++) begin : g_col
          if (gc == K - 1) begin : g_edge
            assign win_d[((gi*K + gr)*K + gc)*DW +: DW] = col_pix[gr];
          end else begin : g_shift
            assign win_d[((gi*K + gr)*K + gc)*DW +: DW] = sh_q[gr][gc];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (accept) begin
          for (int r = 0; r < K - 1; r++) begin
            lb_q[r][col_q] <= col_pix[r+1];
          end
          for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
              sh_q[r][c] <= win_d[((gi*K + r)*K + c + 1)*DW +: DW];
            end
          end
        end
      end
    end
  endgenerate

`ifdef S2WB_COORD_EN
  logic [3:0] win_row_q;
  logic [3:0] win_col_q;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || frame_clr) begin
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef S2WB_COORD_EN
      win_row_q    <= '0;
      win_col_q    <= '0;
`endif
    end else begin
      frame_done_q <= accept && last_pix;
      if (accept) begin
        if (col_q == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (complete) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_d;
        win_last_q  <= last_pix;
        if (win_valid_q && !win_ready) begin
          overflow_q <= 1'b1;
        end
`ifdef S2WB_COORD_EN
        win_row_q <= 4'(row_q - RW'(K - 1));
        win_col_q <= 4'(col_q - CW'(K - 1));
`endif
      end else if (win_valid_q && win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_s2_window_buffer.sv
// Scoreboard bench for s2_window_buffer: a frame-image model builds each expected window,
// a monitor pops and compares on every handshake.
module tb_s2_window_buffer;
  localparam int W  = 14;
  localparam int H  = 14;
  localparam int K  = 5;
  localparam int CH = 6;
  localparam int DW = 8;
  localparam int WW = CH * K * K * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_clr = 1'b0;
  logic in_valid = 1'b0;
  logic win_ready = 1'b0;
  logic [CH*DW-1:0] in_data = '0;
  logic win_valid, win_last, frame_done, overflow;
  logic [WW-1:0] win_data;
`ifdef S2WB_COORD_EN
  logic [3:0] win_row, win_col;
`endif

  always #5 clk = ~clk;

  s2_window_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_clr  (frame_clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_last   (win_last),
    .frame_done (frame_done),
    .overflow   (overflow)
`ifdef S2WB_COORD_EN
    ,
    .win_row    (win_row),
    .win_col    (win_col)
`endif
  );

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
    logic [3:0]    r;
    logic [3:0]    c;
  } win_t;

  win_t          exp_q[$];
  logic [WW-1:0] acc_hist[$];
  logic [7:0]    img [CH][H][W];
  win_t          last_built;
  win_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  int            fd_cnt = 0;
  bit            rand_ready = 1'b0;
  logic          ready_val = 1'b1;
  bit            prev_low = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int elem(input logic [WW-1:0] w, input int ch, input int r, input int c);
    return int'(w[((ch*K + r)*K + c)*DW +: DW]);
  endfunction

  // Window whose bottom-right pixel is (r,c), taken straight from the model image.
  function automatic win_t build(input int r, input int c);
    win_t w;
    w.data = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w.data[((ch*K + i)*K + j)*DW +: DW] = img[ch][r-K+1+i][c-K+1+j];
    w.last = (r == H - 1) && (c == W - 1);
    w.r = 4'(r - K + 1);
    w.c = 4'(c - K + 1);
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) win_ready = prev_low ? 1'b1 : 1'($urandom_range(0, 1));
      else            win_ready = ready_val;
      prev_low = !win_ready;
    end
  end

  always @(negedge clk) begin
    if (rst_n && frame_done) fd_cnt++;
    if (rst_n && win_valid && win_ready) begin
      acc_hist.push_back(win_data);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window actual=%0h required=none", win_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("win_data", win_data, mon_e.data);
        chki("win_last", int'(win_last), int'(mon_e.last));
`ifdef S2WB_COORD_EN
        chki("win_row", int'(win_row), int'(mon_e.r));
        chki("win_col", int'(win_col), int'(mon_e.c));
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    chki({tag, "_valid"}, int'(win_valid), 0);
    chki({tag, "_last"}, int'(win_last), 0);
    chki({tag, "_frame_done"}, int'(frame_done), 0);
    chki({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_data"}, win_data, '0);
`ifdef S2WB_COORD_EN
    chki({tag, "_row"}, int'(win_row), 0);
    chki({tag, "_col"}, int'(win_col), 0);
`endif
  endtask

  // Pixel with frame_clr asserted in the same cycle; the pixel must be discarded.
  task automatic clr_pixel();
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    frame_clr = 1'b1;
    idle(1);
    in_valid = 1'b0;
    frame_clr = 1'b0;
  endtask

  task automatic run_frame(input bit pattern, input int gap, input int n_pix, input bit push);
    int fd0;
    fd0 = fd_cnt;
    for (int p = 0; p < n_pix; p++) begin
      int r;
      int c;
      logic [CH*DW-1:0] d;
      bit done;
      r = p / W;
      c = p % W;
      for (int ch = 0; ch < CH; ch++) begin
        img[ch][r][c] = pattern ? 8'((r*W + c + ch) & 255) : 8'($urandom);
        d[ch*DW +: DW] = img[ch][r][c];
      end
      done = (r >= K - 1) && (c >= K - 1);
      if (done) begin
        last_built = build(r, c);
        if (push) exp_q.push_back(last_built);
      end
      in_valid = 1'b1;
      in_data = d;
      idle(1);
      in_valid = 1'b0;
      if (done) begin
        chki("latency_valid", int'(win_valid), 1);
        chk("latency_data", win_data, last_built.data);
      end
      if (p != n_pix - 1) idle(gap);
    end
    if (n_pix == H * W) begin
      chki("frame_done_pulse", int'(frame_done), 1);
      idle(1);
      chki("frame_done_clear", int'(frame_done), 0);
      chki("frame_done_count", fd_cnt - fd0, 1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    chki("drain_pending", exp_q.size(), 0);
  endtask

  task automatic t1_frame(input string tag);
    int h0;
    logic [WW-1:0] first;
    logic [WW-1:0] last;
    h0 = acc_hist.size();
    run_frame(1'b1, 0, H * W, 1'b1);
    drain();
    chki({tag, "_count"}, acc_hist.size() - h0, 100);
    if (acc_hist.size() >= h0 + 100) begin
      first = acc_hist[h0];
      last = acc_hist[h0 + 99];
      chki({tag, "_first_c0_00"}, elem(first, 0, 0, 0), 0);
      chki({tag, "_first_c0_44"}, elem(first, 0, 4, 4), 60);
      chki({tag, "_first_c5_00"}, elem(first, 5, 0, 0), 5);
      chki({tag, "_last_c0_00"}, elem(last, 0, 0, 0), 135);
      chki({tag, "_last_c0_44"}, elem(last, 0, 4, 4), 195);
    end
  endtask

  initial begin
    int h0;
    rst_n = 1'b0;
    idle(3);
    check_idle("reset");
    rst_n = 1'b1;
    ready_val = 1'b1;
    idle(2);

    t1_frame("t1");
    t1_frame("t2");

    rand_ready = 1'b1;
    h0 = acc_hist.size();
    run_frame(1'b0, 2, H * W, 1'b1);
    drain();
    chki("t4_count", acc_hist.size() - h0, 100);
    chki("t4_overflow", int'(overflow), 0);
    rand_ready = 1'b0;
    ready_val = 1'b0;
    idle(3);

    run_frame(1'b1, 0, 62, 1'b0);
    chki("t3_overflow", int'(overflow), 1);
    chki("t3_valid", int'(win_valid), 1);
    chki("t3_c0_44", elem(win_data, 0, 4, 4), 61);
    idle(3);
    chk("t3_held", win_data, last_built.data);
    clr_pixel();
    check_idle("t3_clr");
    ready_val = 1'b1;
    idle(2);

    run_frame(1'b1, 0, 30, 1'b1);
    clr_pixel();
    check_idle("t6_clr");
    t1_frame("t6");

    run_frame(1'b1, 0, 71, 1'b1);
    rst_n = 1'b0;
    idle(1);
    check_idle("t5_reset");
    chki("t5_pending", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b1;
    idle(1);
    t1_frame("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
